// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU control FSM: opcode decode, IF/ID/EXE/MEM/WB sequencing and datapath
// control, with a variable-latency memory handshake guarded by a saturating timeout.
module multicycle_control_fsm #(
  parameter int unsigned WIDTH_OPCODE = 4,
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned WIDTH_TMO    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH_OPCODE-1:0] opcode,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    IR_Write,
  output logic                    MemToReg,
  output logic                    Mem_Read_not_Write,
  output logic                    Mem_Select,
  output logic [1:0]              PC_Source,
  output logic                    pc_write_enable,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              ALUop,
  output logic                    RegWrite,
  output logic                    halted,
  output logic                    error,
  output logic [3:0]              state_dbg
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_IF        = 4'd1,
    S_ID        = 4'd2,
    S_R_EXE     = 4'd3,
    S_LR_ADDR   = 4'd4,
    S_SR_ADDR   = 4'd5,
    S_BRANCH    = 4'd6,
    S_JUMP      = 4'd7,
    S_HALT      = 4'd8,
    S_MEM_READ  = 4'd9,
    S_MEM_WB    = 4'd10,
    S_MEM_STORE = 4'd11,
    S_ALU_WB    = 4'd12,
    S_ERROR     = 4'd13
  } state_t;

  // Opcodes are zero-extended, so any set upper bit fails every match and decodes to ERROR.
  localparam logic [WIDTH_OPCODE-1:0] OP_NOP  = WIDTH_OPCODE'(0);
  localparam logic [WIDTH_OPCODE-1:0] OP_ADD  = WIDTH_OPCODE'(1);
  localparam logic [WIDTH_OPCODE-1:0] OP_ADDI = WIDTH_OPCODE'(2);
  localparam logic [WIDTH_OPCODE-1:0] OP_LR   = WIDTH_OPCODE'(3);
  localparam logic [WIDTH_OPCODE-1:0] OP_SR   = WIDTH_OPCODE'(4);
  localparam logic [WIDTH_OPCODE-1:0] OP_BNEQ = WIDTH_OPCODE'(5);
  localparam logic [WIDTH_OPCODE-1:0] OP_LI   = WIDTH_OPCODE'(6);
  localparam logic [WIDTH_OPCODE-1:0] OP_SUB  = WIDTH_OPCODE'(7);
  localparam logic [WIDTH_OPCODE-1:0] OP_BEQ  = WIDTH_OPCODE'(8);
  localparam logic [WIDTH_OPCODE-1:0] OP_JMP  = WIDTH_OPCODE'(9);
  localparam logic [WIDTH_OPCODE-1:0] OP_HALT = WIDTH_OPCODE'(15);

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUBUF = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_RESET  = 2'd3;

  localparam logic [1:0] SRCB_RT  = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  localparam logic [1:0] ALUOP_ADD = 2'd0;
  localparam logic [1:0] ALUOP_SUB = 2'd1;

  localparam logic [WIDTH_TMO-1:0] TMO_LAST = WIDTH_TMO'(MEM_TIMEOUT - 1);
  localparam logic [WIDTH_TMO-1:0] TMO_MAX  = '1;

  state_t               state;
  state_t               state_next;
  logic [WIDTH_TMO-1:0] tmo_cnt;
  logic                 in_wait;
  logic                 tmo_expired;
  logic                 op_reg_form;
  logic                 op_sub;
  logic                 branch_taken;

  assign in_wait      = (state == S_IF) || (state == S_MEM_READ) || (state == S_MEM_STORE);
  assign tmo_expired  = (tmo_cnt == TMO_LAST) && !mem_ready;
  assign op_reg_form  = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign op_sub       = (opcode == OP_SUB);
  assign branch_taken = ((opcode == OP_BNEQ) && !zero) || ((opcode == OP_BEQ) && zero);
  assign state_dbg    = state;

  // State register and wait-state timeout counter (cleared on every state change).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_RESET;
      tmo_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        tmo_cnt <= '0;
      end else if (in_wait && !mem_ready && (tmo_cnt != TMO_MAX)) begin
        tmo_cnt <= tmo_cnt + WIDTH_TMO'(1);
      end
    end
  end

  // Next-state decode and datapath controls.
  always_comb begin
    state_next         = state;
    IR_Write           = 1'b0;
    MemToReg           = 1'b0;
    Mem_Read_not_Write = 1'b1;
    Mem_Select         = 1'b0;
    PC_Source          = PCS_ALU;
    pc_write_enable    = 1'b0;
    alu_src_a          = 1'b0;
    alu_src_b          = SRCB_RT;
    ALUop              = ALUOP_ADD;
    RegWrite           = 1'b0;
    halted             = 1'b0;
    error              = 1'b0;

    case (state)
      S_RESET: begin
        PC_Source       = PCS_RESET;
        pc_write_enable = 1'b1;
        state_next      = S_IF;
      end
      S_IF: begin
        alu_src_b = SRCB_ONE;
        if (mem_ready) begin
          IR_Write        = 1'b1;
          pc_write_enable = 1'b1;
          state_next      = S_ID;
        end else if (tmo_expired) begin
          state_next = S_ERROR;
        end
      end
      S_ID: begin
        // Branch target is computed here into the ALU buffer.
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_NOP:                          state_next = S_IF;
          OP_ADD, OP_ADDI, OP_LI, OP_SUB:  state_next = S_R_EXE;
          OP_LR:                           state_next = S_LR_ADDR;
          OP_SR:                           state_next = S_SR_ADDR;
          OP_BNEQ, OP_BEQ:                 state_next = S_BRANCH;
          OP_JMP:                          state_next = S_JUMP;
          OP_HALT:                         state_next = S_HALT;
          default:                         state_next = S_ERROR;
        endcase
      end
      S_R_EXE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = op_reg_form ? SRCB_RT : SRCB_IMM;
        ALUop      = op_sub ? ALUOP_SUB : ALUOP_ADD;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite   = 1'b1;
        state_next = S_IF;
      end
      S_LR_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = S_MEM_READ;
      end
      S_SR_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = S_MEM_STORE;
      end
      S_MEM_READ: begin
        Mem_Select = 1'b1;
        if (mem_ready) begin
          state_next = S_MEM_WB;
        end else if (tmo_expired) begin
          state_next = S_ERROR;
        end
      end
      S_MEM_WB: begin
        Mem_Select = 1'b1;
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        state_next = S_IF;
      end
      S_MEM_STORE: begin
        Mem_Select         = 1'b1;
        Mem_Read_not_Write = 1'b0;
        if (mem_ready) begin
          state_next = S_IF;
        end else if (tmo_expired) begin
          state_next = S_ERROR;
        end
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        ALUop      = ALUOP_SUB;
        if (branch_taken) begin
          pc_write_enable = 1'b1;
          PC_Source       = PCS_ALUBUF;
        end
        state_next = S_IF;
      end
      S_JUMP: begin
        PC_Source       = PCS_JUMP;
        pc_write_enable = 1'b1;
        state_next      = S_IF;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: begin
        state_next = S_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed scenarios plus a random instruction stream
// checked against a phase-level reference model.
module tb_multicycle_control_fsm;

  localparam int unsigned TMO = 4;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_LR   = 4'd3;
  localparam logic [3:0] OP_SR   = 4'd4;
  localparam logic [3:0] OP_BNEQ = 4'd5;
  localparam logic [3:0] OP_LI   = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef struct packed {
    logic       ir_write;
    logic       mem_to_reg;
    logic       mem_rnw;
    logic       mem_sel;
    logic [1:0] pc_src;
    logic       pc_we;
    logic       alu_a;
    logic [1:0] alu_b;
    logic [1:0] aluop;
    logic       reg_write;
    logic       halted;
    logic       error;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       IR_Write, MemToReg, Mem_Read_not_Write, Mem_Select;
  logic [1:0] PC_Source;
  logic       pc_write_enable, alu_src_a;
  logic [1:0] alu_src_b, ALUop;
  logic       RegWrite, halted, error;
  logic [3:0] state_dbg;
  outs_t      act;

  int checks = 0;
  int passes = 0;
  int q_st[$];
  bit q_rdy[$];

  multicycle_control_fsm #(.WIDTH_OPCODE(4), .MEM_TIMEOUT(TMO), .WIDTH_TMO(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .IR_Write(IR_Write), .MemToReg(MemToReg), .Mem_Read_not_Write(Mem_Read_not_Write),
    .Mem_Select(Mem_Select), .PC_Source(PC_Source), .pc_write_enable(pc_write_enable),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUop(ALUop), .RegWrite(RegWrite),
    .halted(halted), .error(error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign act = {IR_Write, MemToReg, Mem_Read_not_Write, Mem_Select, PC_Source, pc_write_enable,
                alu_src_a, alu_src_b, ALUop, RegWrite, halted, error};

  // Control outputs the documented behaviour requires in a given state.
  function automatic outs_t exp_outs(int st, logic [3:0] op, logic z, logic rdy);
    outs_t o = '0;
    o.mem_rnw = 1'b1;
    case (st)
      0:  begin o.pc_src = 2'd3; o.pc_we = 1'b1; end
      1:  begin o.alu_b = 2'd1; if (rdy) begin o.ir_write = 1'b1; o.pc_we = 1'b1; end end
      2:  o.alu_b = 2'd2;
      3:  begin
            o.alu_a = 1'b1;
            o.alu_b = (op == OP_ADD || op == OP_SUB) ? 2'd0 : 2'd2;
            o.aluop = (op == OP_SUB) ? 2'd1 : 2'd0;
          end
      4, 5: begin o.alu_a = 1'b1; o.alu_b = 2'd2; end
      6:  begin
            o.alu_a = 1'b1; o.aluop = 2'd1;
            if ((op == OP_BNEQ && !z) || (op == OP_BEQ && z)) begin o.pc_we = 1'b1; o.pc_src = 2'd1; end
          end
      7:  begin o.pc_src = 2'd2; o.pc_we = 1'b1; end
      8:  o.halted = 1'b1;
      9:  o.mem_sel = 1'b1;
      10: begin o.mem_sel = 1'b1; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      11: begin o.mem_sel = 1'b1; o.mem_rnw = 1'b0; end
      12: o.reg_write = 1'b1;
      13: o.error = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  // Number of not-ready cycles in a wait phase; TMO means the wait never completes.
  function automatic int pick_wait();
    if ($urandom_range(0, 7) == 0) return int'(TMO);
    return int'($urandom_range(0, TMO - 1));
  endfunction

  task automatic push_st(input int st);
    q_st.push_back(st);
    q_rdy.push_back(1'($urandom));
  endtask

  task automatic plan_wait(input int st, input int k, output bit done);
    for (int i = 0; i < k; i++) begin q_st.push_back(st); q_rdy.push_back(1'b0); end
    done = (k < int'(TMO));
    if (done) begin q_st.push_back(st); q_rdy.push_back(1'b1); end
    else push_st(13);
  endtask

  // Expected per-cycle state path of one instruction, from fetch to its last cycle.
  task automatic plan_instr(input logic [3:0] op);
    bit ok;
    plan_wait(1, pick_wait(), ok);
    if (!ok) return;
    push_st(2);
    case (op)
      OP_NOP: ;
      OP_ADD, OP_ADDI, OP_LI, OP_SUB: begin push_st(3); push_st(12); end
      OP_LR: begin push_st(4); plan_wait(9, pick_wait(), ok); if (ok) push_st(10); end
      OP_SR: begin push_st(5); plan_wait(11, pick_wait(), ok); end
      OP_BNEQ, OP_BEQ: push_st(6);
      OP_JMP: push_st(7);
      OP_HALT: push_st(8);
      default: push_st(13);
    endcase
  endtask

  task automatic cyc(input logic [3:0] op, input logic z, input logic rdy);
    @(negedge clk);
    opcode = op; zero = z; mem_ready = rdy;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1; opcode = OP_ADD; mem_ready = 1'b1; #1;
    checks++; if (state_dbg !== 4'd0) $display("FAIL reset_state got %0d want 0", state_dbg); else passes++;
    checks++; if (act !== exp_outs(0, OP_ADD, 1'b0, 1'b1)) $display("FAIL reset_outs got %h want %h", act, exp_outs(0, OP_ADD, 1'b0, 1'b1)); else passes++;
    @(posedge clk); #1;
    checks++; if (state_dbg !== 4'd0) $display("FAIL reset_hold got %0d want 0", state_dbg); else passes++;
    @(negedge clk); reset = 1'b0;
    cyc(OP_NOP, 1'b0, 1'b1);
    checks++; if (state_dbg !== 4'd1 || IR_Write !== 1'b1) $display("FAIL reset_to_if state %0d irw %b want 1/1", state_dbg, IR_Write); else passes++;
    cyc(OP_NOP, 1'b0, 1'b1);
    checks++; if (state_dbg !== 4'd2) $display("FAIL nop_id got %0d want 2", state_dbg); else passes++;
    cyc(OP_ADD, 1'b0, 1'b1);
    checks++; if (state_dbg !== 4'd1) $display("FAIL nop_back_if got %0d want 1", state_dbg); else passes++;
    cyc(OP_ADD, 1'b0, 1'b1);
    #2 reset = 1'b1; #1;
    checks++; if (state_dbg !== 4'd0 || act !== exp_outs(0, OP_ADD, 1'b0, 1'b1)) $display("FAIL async_reset state %0d outs %h want 0/%h", state_dbg, act, exp_outs(0, OP_ADD, 1'b0, 1'b1)); else passes++;
    @(negedge clk); reset = 1'b0;
    cyc(OP_NOP, 1'b0, 1'b1);
    checks++; if (state_dbg !== 4'd1) $display("FAIL async_release got %0d want 1", state_dbg); else passes++;
  endtask

  task automatic test_alu_ops();
    logic [3:0] ops [4] = '{OP_ADD, OP_SUB, OP_ADDI, OP_LI};
    int exp_st [4] = '{1, 2, 3, 12};
    apply_reset();
    foreach (ops[j]) begin
      for (int i = 0; i < 4; i++) begin
        cyc(ops[j], 1'($urandom), 1'b1);
        checks++; if (state_dbg !== 4'(exp_st[i]) || RegWrite !== (i == 3)) $display("FAIL alu_seq op %0d step %0d state %0d rw %b want %0d/%b", ops[j], i, state_dbg, RegWrite, exp_st[i], i == 3); else passes++;
        if (i == 2) begin
          checks++;
          if (ALUop !== ((ops[j] == OP_SUB) ? 2'd1 : 2'd0) || alu_src_a !== 1'b1 ||
              alu_src_b !== ((ops[j] == OP_ADD || ops[j] == OP_SUB) ? 2'd0 : 2'd2))
            $display("FAIL alu_exe op %0d aluop %0d a %b b %0d", ops[j], ALUop, alu_src_a, alu_src_b);
          else passes++;
        end
      end
    end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    cyc(OP_LR, 1'b0, 1'b1); cyc(OP_LR, 1'b0, 1'b1); cyc(OP_LR, 1'b0, 1'b1);
    checks++; if (state_dbg !== 4'd4) $display("FAIL lr_addr got %0d want 4", state_dbg); else passes++;
    for (int i = 0; i < 4; i++) begin
      cyc(OP_LR, 1'b0, i == 3);
      checks++; if (state_dbg !== 4'd9 || Mem_Select !== 1'b1 || RegWrite !== 1'b0) $display("FAIL lr_wait cyc %0d state %0d sel %b rw %b", i, state_dbg, Mem_Select, RegWrite); else passes++;
    end
    cyc(OP_LR, 1'b0, 1'b0);
    checks++; if (state_dbg !== 4'd10 || MemToReg !== 1'b1 || RegWrite !== 1'b1) $display("FAIL lr_wb state %0d m2r %b rw %b want 10/1/1", state_dbg, MemToReg, RegWrite); else passes++;
    cyc(OP_SR, 1'b0, 1'b1); cyc(OP_SR, 1'b0, 1'b1); cyc(OP_SR, 1'b0, 1'b1);
    checks++; if (state_dbg !== 4'd5) $display("FAIL sr_addr got %0d want 5", state_dbg); else passes++;
    cyc(OP_SR, 1'b0, 1'b1);
    checks++; if (state_dbg !== 4'd11 || Mem_Read_not_Write !== 1'b0 || Mem_Select !== 1'b1) $display("FAIL sr_store state %0d rnw %b sel %b", state_dbg, Mem_Read_not_Write, Mem_Select); else passes++;
    cyc(OP_NOP, 1'b0, 1'b1);
    checks++; if (state_dbg !== 4'd1) $display("FAIL sr_back_if got %0d want 1", state_dbg); else passes++;
  endtask

  task automatic test_back_to_back_branches();
    logic [3:0] op;
    logic z, tk;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      op = (c == 4) ? OP_JMP : ((c < 2) ? OP_BEQ : OP_BNEQ);
      z  = 1'(c);
      tk = (op == OP_BEQ) ? z : !z;
      cyc(op, z, 1'b1); cyc(op, z, 1'b1); cyc(op, z, 1'b1);
      if (op == OP_JMP) begin
        checks++; if (state_dbg !== 4'd7 || pc_write_enable !== 1'b1 || PC_Source !== 2'd2) $display("FAIL jmp state %0d we %b src %0d", state_dbg, pc_write_enable, PC_Source); else passes++;
      end else begin
        checks++;
        if (state_dbg !== 4'd6 || pc_write_enable !== tk || PC_Source !== (tk ? 2'd1 : 2'd0) || ALUop !== 2'd1)
          $display("FAIL branch op %0d z %b state %0d we %b src %0d want 6/%b", op, z, state_dbg, pc_write_enable, PC_Source, tk);
        else passes++;
      end
    end
    cyc(OP_NOP, 1'b0, 1'b1);
    checks++; if (state_dbg !== 4'd1) $display("FAIL branch_back_if got %0d want 1", state_dbg); else passes++;
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < int'(TMO); i++) begin
      cyc(OP_NOP, 1'b0, 1'b0);
      checks++; if (state_dbg !== 4'd1 || pc_write_enable !== 1'b0 || IR_Write !== 1'b0) $display("FAIL if_wait cyc %0d state %0d we %b irw %b", i, state_dbg, pc_write_enable, IR_Write); else passes++;
    end
    for (int i = 0; i < 10; i++) begin
      cyc(4'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (state_dbg !== 4'd13 || error !== 1'b1 || {pc_write_enable, RegWrite, IR_Write, Mem_Select} !== 4'b0)
        $display("FAIL timeout_err cyc %0d state %0d err %b", i, state_dbg, error);
      else passes++;
    end
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < int'(TMO); i++) begin
        cyc(OP_NOP, 1'b0, i == int'(TMO) - 1);
        checks++; if (state_dbg !== 4'd1 || IR_Write !== (i == int'(TMO) - 1)) $display("FAIL last_cycle_ready pass %0d cyc %0d state %0d irw %b", r, i, state_dbg, IR_Write); else passes++;
      end
      cyc(OP_NOP, 1'b0, 1'b0);
      checks++; if (state_dbg !== 4'd2) $display("FAIL last_cycle_id pass %0d got %0d want 2", r, state_dbg); else passes++;
    end
  endtask

  task automatic test_illegal_halt();
    apply_reset();
    cyc(4'd10, 1'b0, 1'b1); cyc(4'd10, 1'b0, 1'b1); cyc(4'd10, 1'b0, 1'b1);
    checks++; if (state_dbg !== 4'd13 || error !== 1'b1) $display("FAIL illegal_op state %0d err %b want 13/1", state_dbg, error); else passes++;
    apply_reset();
    cyc(OP_HALT, 1'b0, 1'b1); cyc(OP_HALT, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      cyc(4'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (state_dbg !== 4'd8 || act !== exp_outs(8, opcode, zero, mem_ready))
        $display("FAIL halt_sticky cyc %0d state %0d outs %h", i, state_dbg, act);
      else passes++;
    end
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (state_dbg !== 4'd0 || halted !== 1'b0) $display("FAIL halt_reset state %0d halted %b", state_dbg, halted); else passes++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_random_program();
    logic [3:0] op;
    logic z;
    int st = 0;
    bit rdy;
    apply_reset();
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 15))
        0: op = 4'(10 + $urandom_range(0, 4));
        1: op = OP_HALT;
        default: op = 4'($urandom_range(0, 9));
      endcase
      z = 1'($urandom);
      q_st.delete(); q_rdy.delete();
      plan_instr(op);
      while (q_st.size() > 0) begin
        st  = q_st.pop_front();
        rdy = q_rdy.pop_front();
        cyc(op, z, rdy);
        checks++; if (state_dbg !== 4'(st)) $display("FAIL rand_state instr %0d op %0d got %0d want %0d", n, op, state_dbg, st); else passes++;
        checks++; if (act !== exp_outs(st, op, z, rdy)) $display("FAIL rand_outs instr %0d op %0d st %0d got %h want %h", n, op, st, act, exp_outs(st, op, z, rdy)); else passes++;
      end
      if (st == 8 || st == 13) begin
        for (int i = 0; i < 4; i++) begin
          cyc(4'($urandom), 1'($urandom), 1'($urandom));
          checks++; if (state_dbg !== 4'(st) || act !== exp_outs(st, opcode, zero, mem_ready)) $display("FAIL rand_sticky instr %0d got %0d want %0d", n, state_dbg, st); else passes++;
        end
        apply_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_mem_wait();
    test_back_to_back_branches();
    test_timeout();
    test_illegal_halt();
    test_random_program();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
